// File: rtl/qcore_reg_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : qcore_reg_wr_arb
//  Brief    : Register-bank write arbiter: core writeback > host / block-fill
//             (round-robin), with a registered write port and conflict counter.
//  Revision : 1.0  initial release
// ============================================================================
module qcore_reg_wr_arb #(
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              halt_i,
    input  logic              clear_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_dt_i,
    input  logic              ext_req_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [31:0]       ext_dt_i,
    output logic              ext_ack_o,
    input  logic              init_start_i,
    input  logic [ADDR_W-1:0] init_first_i,
    input  logic [ADDR_W-1:0] init_last_i,
    input  logic [31:0]       init_dt_i,
    output logic              init_busy_o,
    output logic              init_done_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [31:0]       w_dt_o,
    output logic [15:0]       conflict_cnt_o
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fill_state_t;

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] w_last_nxt;
    logic [31:0]       r_dt;
    logic [31:0]       w_dt_nxt;
    logic              r_last_ext;

    logic w_active;
    logic w_fill_req;
    logic w_core_gnt;
    logic w_ext_gnt;
    logic w_fill_gnt;
    logic w_ext_unmapped;
    logic w_conflict;

    // rst_i is folded in so the combinational ack is also quiet during reset.
    assign w_active   = ~halt_i & ~clear_i & ~rst_i;
    assign w_fill_req = (r_state == S_RUN);
    assign w_core_gnt = w_active & core_we_i;
    // r_last_ext == 1 means ext won the previous ext/fill grant, so fill wins a tie.
    assign w_ext_gnt  = w_active & ~core_we_i & ext_req_i & (~w_fill_req | ~r_last_ext);
    assign w_fill_gnt = w_active & ~core_we_i & w_fill_req & (~ext_req_i | r_last_ext);

    assign w_ext_unmapped = (ext_addr_i[ADDR_W-1 -: 2] == 2'b11);
    assign w_conflict     = ~halt_i & core_we_i & (ext_req_i | w_fill_req);

    assign ext_ack_o   = w_ext_gnt;
    assign init_busy_o = (r_state == S_RUN) | (r_state == S_DONE);
    assign init_done_o = (r_state == S_DONE);

    // Fill FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
            r_dt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_dt    <= w_dt_nxt;
        end
    end

    // Fill FSM: next-state logic; halt freezes everything, clear aborts silently
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_dt_nxt    = r_dt;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (!halt_i) begin
            case (r_state)
                S_IDLE: begin
                    if (init_start_i) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = init_first_i;
                        w_last_nxt  = init_last_i;
                        w_dt_nxt    = init_dt_i;
                    end
                end
                S_RUN: begin
                    if (w_fill_gnt) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == r_last) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Round-robin history; only ext/fill grants move it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_ext <= 1'b0;
        end else if (clear_i) begin
            r_last_ext <= 1'b0;
        end else if (w_ext_gnt) begin
            r_last_ext <= 1'b1;
        end else if (w_fill_gnt) begin
            r_last_ext <= 1'b0;
        end
    end

    // Registered write port: grant in cycle N appears in cycle N+1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_o     <= 1'b0;
            w_addr_o <= '0;
            w_dt_o   <= '0;
        end else begin
            we_o <= w_core_gnt | w_fill_gnt | (w_ext_gnt & ~w_ext_unmapped);
            if (w_core_gnt) begin
                w_addr_o <= core_addr_i;
                w_dt_o   <= core_dt_i;
            end else if (w_ext_gnt) begin
                w_addr_o <= ext_addr_i;
                w_dt_o   <= ext_dt_i;
            end else if (w_fill_gnt) begin
                w_addr_o <= r_cnt;
                w_dt_o   <= r_dt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
        end else if (clear_i) begin
            conflict_cnt_o <= '0;
        end else if (w_conflict && (conflict_cnt_o != c_CNT_MAX)) begin
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/qcore_reg_wr_arb.md
QCORE_REG_WR_ARB -- requirements
Module: qcore_reg_wr_arb

Interface
REQ-001 Parameter ADDR_W, default 7, register-bank write address width; all address ports are ADDR_W bits.
REQ-002 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 halt_i  in  1  core halt; while high, no grants are issued.
REQ-005 clear_i  in  1  synchronous soft clear.
REQ-006 core_we_i / core_addr_i / core_dt_i  in  1/7/32  core writeback request; no backpressure.
REQ-007 ext_req_i / ext_addr_i / ext_dt_i  in  1/7/32  host write request, held stable until ack.
REQ-008 ext_ack_o  out  1  one-cycle acknowledge in the grant cycle.
REQ-009 init_start_i / init_first_i / init_last_i / init_dt_i  in  1/7/7/32  block-fill command.
REQ-010 init_busy_o / init_done_o  out  1/1  fill in progress / one-cycle completion pulse.
REQ-011 we_o / w_addr_o / w_dt_o  out  1/7/32  registered write port to the register bank.
REQ-012 conflict_cnt_o  out  16  count of cycles in which a host or fill requester was blocked by core writeback.

Function
REQ-013 Latency: a grant in cycle N SHALL drive we_o, w_addr_o and w_dt_o in cycle N+1 only; we_o SHALL be 0 in every cycle without a preceding grant.
REQ-014 Priority: core_we_i SHALL always win; ext and fill arbitrate only in cycles where core_we_i is 0.
REQ-015 Round-robin: with ext and fill both pending, the grant SHALL go to the requester not granted last; the last-winner bit updates only on ext/fill grants.
REQ-016 Ext handshake: ext_ack_o=1 exactly in the ext grant cycle; if ext_req_i is still high in the cycle after ack, that is a new request.
REQ-017 Ext writes with ext_addr_i[6:5]==2'b11 (unmapped page) SHALL be acked, with we_o suppressed.
REQ-018 Fill FSM states: IDLE, RUN, DONE.
  - IDLE: init_start_i latches first, last and dt, loads cnt=first, and goes to RUN.
  - RUN: each fill grant writes addr=cnt and data=dt, then cnt=cnt+1 (mod 2^ADDR_W); the grant with cnt==last goes to DONE.
  - DONE: init_done_o=1 for one cycle, then IDLE.
REQ-019 init_busy_o=1 in RUN and DONE; init_start_i outside IDLE SHALL be ignored.
REQ-020 Fill boundaries:
  - first==last: exactly one write.
  - first>last: wrap, writing first..2^ADDR_W-1 then 0..last.
REQ-021 halt_i=1: no grants, ext_ack_o=0, FSM and cnt hold, core_we_i is dropped (not queued), conflict counter holds.
REQ-022 clear_i=1 SHALL win over everything in that cycle:
  - no grant, and we_o=0 next cycle;
  - FSM to IDLE with no done pulse;
  - cnt and counter cleared;
  - last-winner reset to fill.
REQ-023 conflict_cnt_o SHALL increment when halt_i=0 & core_we_i=1 & (ext_req_i | FSM==RUN), saturating at 16'hFFFF.
REQ-024 init_start_i and ext_req_i in the same cycle: start is latched, ext arbitrates normally, and fill competes from the next cycle.

Reset
REQ-025 While rst_i=1, and immediately on assertion: we_o=0, w_addr_o=0, w_dt_o=0, ext_ack_o=0, init_busy_o=0, init_done_o=0, conflict_cnt_o=0, FSM=IDLE, cnt=0, last-winner=fill (so ext wins the first tie).
REQ-026 Reset mid-fill SHALL abort the fill with no done pulse; after release the block waits for a new init_start_i.

Verification
REQ-027 Core only: core_we_i=1, addr=0x05, dt=0xDEADBEEF at cycle N -> we_o=1, w_addr_o=0x05, w_dt_o=0xDEADBEEF at N+1.
REQ-028 Core + ext collide for 3 cycles, then core idle -> ext_ack_o in the 4th cycle, ext write at the 5th, conflict_cnt_o=3.
REQ-029 Fill first=0x00, last=0x0F, dt=0, with ext held requesting -> grants alternate ext/fill starting with ext, 16 fill writes 0x00..0x0F, one init_done_o pulse.
REQ-030 Fill first=0x7E, last=0x01 -> writes 0x7E, 0x7F, 0x00, 0x01, then done.
REQ-031 halt_i for 4 cycles mid-fill, then clear_i mid-fill -> no writes during halt, cnt resumes unchanged; after clear, init_busy_o=0 with no done pulse.
REQ-032 Ext write to addr 0x60 -> ext_ack_o=1, we_o stays 0.
